// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-bus responder: access sizes and load FSM states.
package dmem_responder_pkg;

    localparam logic [1:0] DSIZE_B = 2'b00;
    localparam logic [1:0] DSIZE_H = 2'b01;
    localparam logic [1:0] DSIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RWAIT = 2'b01,
        RDONE = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port handshake. ddata is bidirectional and stays a plain port on the responder.
interface dmem_responder_if;
    logic        dreq;
    logic        dwrite;
    logic [31:0] daddr;
    logic [1:0]  dsize;
    logic        dready_n;
    logic        dbusy;

    modport master (
        output dreq, dwrite, daddr, dsize,
        input  dready_n, dbusy
    );

    modport slave (
        input  dreq, dwrite, daddr, dsize,
        output dready_n, dbusy
    );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering: store mask/data placement and right-justified, zero-extended load extract.
module dmem_responder_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_mask,
    output logic [31:0] st_lane_data,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    // Replicating the low byte/half across the word lets the mask alone pick the lane.
    always_comb begin
        st_mask      = 4'b1111;
        st_lane_data = st_data;
        case (st_size)
            DSIZE_B: begin
                st_mask      = 4'b0001 << st_addr_lo;
                st_lane_data = {4{st_data[7:0]}};
            end
            DSIZE_H: begin
                st_mask      = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lane_data = {2{st_data[15:0]}};
            end
            default: begin
                st_mask      = 4'b1111;
                st_lane_data = st_data;
            end
        endcase
    end

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            DSIZE_B: ld_data = {24'd0, 8'(ld_word >> {ld_addr_lo, 3'b000})};
            DSIZE_H: ld_data = {16'd0, ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus target: wait-stated loads from a byte-lane RAM, stores posted through a one-entry buffer.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [31:0] BASE    = 32'h0002_0000,
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    inout  wire  [31:0]      ddata
);

    localparam int AW = $clog2(DEPTH);

    // Address decode on the live request
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;

    assign offset   = bus.daddr - BASE;
    assign in_range = (bus.daddr >= BASE) && ((offset >> 2) < DEPTH);
    assign idx      = offset[AW+1:2];

    logic [3:0]  st_mask;
    logic [31:0] st_lane_data;
    logic [31:0] ld_word;
    logic [31:0] ld_data;

    // Load FSM and captured request
    state_e        state_q, state_d;
    logic [15:0]   rcnt_q, rcnt_d;
    logic [AW-1:0] lidx_q, lidx_d;
    logic          lok_q, lok_d;
    logic [1:0]    llo_q, llo_d;
    logic [1:0]    lsize_q, lsize_d;

    // Posted write buffer
    logic          wvalid_q, wvalid_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic [AW-1:0] widx_q, widx_d;
    logic          wok_q, wok_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [31:0]   wdata_q, wdata_d;

    logic ld_start;
    logic st_accept;
    logic mem_we;
    logic rd_en;
    logic [31:0] rword;

    assign ld_start  = bus.dreq && !bus.dwrite && !wvalid_q;
    assign st_accept = bus.dreq && bus.dwrite && !wvalid_q;
    assign mem_we    = wvalid_q && (wcnt_q == 16'd1) && wok_q;
    assign rd_en     = (state_d == RDONE);

    dmem_responder_lane_align u_align (
        .st_addr_lo   (bus.daddr[1:0]),
        .st_size      (bus.dsize),
        .st_data      (ddata),
        .st_mask      (st_mask),
        .st_lane_data (st_lane_data),
        .ld_addr_lo   (llo_q),
        .ld_size      (lsize_q),
        .ld_word      (ld_word),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        lidx_d  = lidx_q;
        lok_d   = lok_q;
        llo_d   = llo_q;
        lsize_d = lsize_q;
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    lidx_d  = idx;
                    lok_d   = in_range;
                    llo_d   = bus.daddr[1:0];
                    lsize_d = bus.dsize;
                    if (RD_WAIT > 1) begin
                        state_d = RWAIT;
                        rcnt_d  = 16'(RD_WAIT - 2);
                    end else begin
                        state_d = RDONE;
                    end
                end
            end
            RWAIT: begin
                if (rcnt_q == 16'd0) begin
                    state_d = RDONE;
                end else begin
                    rcnt_d = rcnt_q - 16'd1;
                end
            end
            RDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The commit edge is the one where the count is 1, so dbusy spans exactly WR_WAIT cycles.
    always_comb begin
        wvalid_d = wvalid_q;
        wcnt_d   = wcnt_q;
        widx_d   = widx_q;
        wok_d    = wok_q;
        wmask_d  = wmask_q;
        wdata_d  = wdata_q;
        if (wvalid_q) begin
            wcnt_d = wcnt_q - 16'd1;
            if (wcnt_q == 16'd1) begin
                wvalid_d = 1'b0;
            end
        end
        if (st_accept) begin
            wvalid_d = 1'b1;
            wcnt_d   = 16'(WR_WAIT);
            widx_d   = idx;
            wok_d    = in_range;
            wmask_d  = st_mask;
            wdata_d  = st_lane_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            lidx_q   <= '0;
            lok_q    <= 1'b0;
            llo_q    <= '0;
            lsize_q  <= '0;
            wvalid_q <= 1'b0;
            wcnt_q   <= '0;
            widx_q   <= '0;
            wok_q    <= 1'b0;
            wmask_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            lidx_q   <= lidx_d;
            lok_q    <= lok_d;
            llo_q    <= llo_d;
            lsize_q  <= lsize_d;
            wvalid_q <= wvalid_d;
            wcnt_q   <= wcnt_d;
            widx_q   <= widx_d;
            wok_q    <= wok_d;
            wmask_q  <= wmask_d;
            wdata_q  <= wdata_d;
        end
    end

    // One RAM per byte lane; the read is registered on the edge that enters RDONE.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_byte;
        always_ff @(posedge clk) begin
            if (mem_we && wmask_q[gi]) begin
                lane_mem[widx_q] <= wdata_q[8*gi +: 8];
            end
            if (rd_en) begin
                rd_byte <= lane_mem[lidx_d];
            end
        end
        assign rword[8*gi +: 8] = rd_byte;
    end

    assign ld_word      = lok_q ? rword : 32'd0;
    assign ddata        = (state_q == RDONE) ? ld_data : 'z;
    assign bus.dready_n = (state_q != RDONE);
    assign bus.dbusy    = wvalid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: one default instance and one with RD_WAIT=3.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0002_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        drv_en0, drv_en1;
    logic [31:0] drv_data0, drv_data1;
    wire  [31:0] ddata0, ddata1;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    assign ddata0 = drv_en0 ? drv_data0 : 'z;
    assign ddata1 = drv_en1 ? drv_data1 : 'z;

    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .RD_WAIT(1), .WR_WAIT(2)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(bus0), .ddata(ddata0)
    );

    dmem_responder #(.DEPTH(DEPTH), .BASE(BASE), .RD_WAIT(3), .WR_WAIT(2)) u_dut1 (
        .clk(clk), .rst(rst1), .bus(bus1), .ddata(ddata1)
    );

    task automatic drive(input int u, input logic req, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic den, input logic [31:0] data);
        if (u == 0) begin
            bus0.dreq = req; bus0.dwrite = wr; bus0.daddr = addr; bus0.dsize = size;
            drv_en0 = den; drv_data0 = data;
        end else begin
            bus1.dreq = req; bus1.dwrite = wr; bus1.daddr = addr; bus1.dsize = size;
            drv_en1 = den; drv_data1 = data;
        end
    endtask

    task automatic set_drv(input int u, input logic den, input logic [31:0] data);
        if (u == 0) begin drv_en0 = den; drv_data0 = data; end
        else begin drv_en1 = den; drv_data1 = data; end
    endtask

    function automatic logic rdy_n(input int u);
        return (u == 0) ? bus0.dready_n : bus1.dready_n;
    endfunction

    function automatic logic busy(input int u);
        return (u == 0) ? bus0.dbusy : bus1.dbusy;
    endfunction

    function automatic logic [31:0] rd_data(input int u);
        return (u == 0) ? ddata0 : ddata1;
    endfunction

    task automatic do_store(input int u, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic drain, input int exp_busy);
        int n;
        @(negedge clk);
        n = 0;
        while (busy(u) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy(u) !== 1'b0) begin
            bad++;
            $display("FAIL store_idle_wait u%0d: dbusy=%b want 0", u, busy(u));
        end
        drive(u, 1'b1, 1'b1, addr, size, 1'b1, data);
        @(posedge clk); #1;
        drive(u, 1'b0, 1'b0, addr, size, 1'b0, 32'd0);
        total++;
        if (busy(u) !== 1'b1) begin
            bad++;
            $display("FAIL store_accept u%0d addr=%h: dbusy=%b want 1", u, addr, busy(u));
        end
        n = 0;
        if (drain) begin
            while (busy(u) && n < 50) begin
                n++;
                @(posedge clk); #1;
            end
            if (exp_busy >= 0) begin
                total++;
                if (n != exp_busy) begin
                    bad++;
                    $display("FAIL store_busy_len u%0d addr=%h: cycles=%0d want %0d", u, addr, n, exp_busy);
                end
            end
        end
        $display("store u%0d addr=%h size=%0d data=%h busy_cycles=%0d", u, addr, size, data, n);
    endtask

    task automatic do_load(input int u, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] expv, input int exp_lat);
        int n;
        logic done;
        logic [31:0] got, want;
        exp_q.push_back(expv);
        @(negedge clk);
        drive(u, 1'b1, 1'b0, addr, size, 1'b0, 32'd0);
        n = 0;
        done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
            if (busy(u) === 1'b1) begin
                total++;
                if (rdy_n(u) !== 1'b1) begin
                    bad++;
                    $display("FAIL load_during_busy u%0d addr=%h: dready_n=%b want 1", u, addr, rdy_n(u));
                end
            end
            if (rdy_n(u) === 1'b0) done = 1'b1;
        end
        want = exp_q.pop_front();
        got  = rd_data(u);
        drive(u, 1'b0, 1'b0, addr, size, 1'b0, 32'd0);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL load_timeout u%0d addr=%h: no dready_n pulse in %0d cycles", u, addr, n);
        end else begin
            if (got !== want) begin
                bad++;
                $display("FAIL load_data u%0d addr=%h: got=%h want=%h", u, addr, got, want);
            end
            if (exp_lat >= 0) begin
                total++;
                if (n != exp_lat) begin
                    bad++;
                    $display("FAIL load_latency u%0d addr=%h: cycles=%0d want %0d", u, addr, n, exp_lat);
                end
            end
        end
        @(negedge clk);
        total++;
        if (rdy_n(u) !== 1'b1) begin
            bad++;
            $display("FAIL ready_pulse_width u%0d: dready_n=%b want 1", u, rdy_n(u));
        end
        // Bus must be released once the pulse ends: a zero driven by the bench must read back unchanged
        set_drv(u, 1'b1, 32'd0);
        #1;
        total++;
        if (rd_data(u) !== 32'd0) begin
            bad++;
            $display("FAIL ddata_released u%0d: got=%h want=00000000", u, rd_data(u));
        end
        set_drv(u, 1'b0, 32'd0);
        $display("load u%0d addr=%h size=%0d data=%h latency=%0d", u, addr, size, got, n);
    endtask

    task automatic test_reset();
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_drv(0, 1'b1, 32'hA5A5_5A5A);
            #1;
            total++;
            if (bus0.dready_n !== 1'b1 || bus1.dready_n !== 1'b1) begin
                bad++;
                $display("FAIL reset_dready_n cycle %0d: got=%b%b want 11", i, bus0.dready_n, bus1.dready_n);
            end
            total++;
            if (bus0.dbusy !== 1'b0 || bus1.dbusy !== 1'b0) begin
                bad++;
                $display("FAIL reset_dbusy cycle %0d: got=%b%b want 00", i, bus0.dbusy, bus1.dbusy);
            end
            total++;
            if (ddata0 !== 32'hA5A5_5A5A) begin
                bad++;
                $display("FAIL reset_ddata_z cycle %0d: got=%h want=a5a55a5a", i, ddata0);
            end
            set_drv(0, 1'b0, 32'd0);
        end
        $display("reset released, idle outputs sampled for 10 cycles");
    endtask

    task automatic test_word_rw();
        do_store(0, BASE + 32'h10, DSIZE_W, 32'hDEAD_BEEF, 1'b1, 2);
        do_load(0, BASE + 32'h10, DSIZE_W, 32'hDEAD_BEEF, 1);
    endtask

    task automatic test_subword();
        do_store(0, BASE + 32'h13, DSIZE_B, 32'h0000_00A5, 1'b1, 2);
        do_store(0, BASE + 32'h10, DSIZE_H, 32'h0000_1234, 1'b1, 2);
        do_load(0, BASE + 32'h10, DSIZE_W, 32'hA5AD_1234, 1);
        do_load(0, BASE + 32'h13, DSIZE_B, 32'h0000_00A5, 1);
        do_load(0, BASE + 32'h12, DSIZE_H, 32'h0000_A5AD, 1);
        do_load(0, BASE + 32'h13, DSIZE_H, 32'h0000_A5AD, 1);
        do_load(0, BASE + 32'h11, DSIZE_B, 32'h0000_0012, 1);
        do_load(0, BASE + 32'h10, DSIZE_H, 32'h0000_1234, 1);
        do_load(0, BASE + 32'h12, 2'b11,   32'hA5AD_1234, 1);
    endtask

    task automatic test_raw_order();
        do_store(0, BASE + 32'h20, DSIZE_W, 32'h1111_1111, 1'b0, -1);
        do_load(0, BASE + 32'h20, DSIZE_W, 32'h1111_1111, -1);
    endtask

    task automatic test_back_to_back();
        logic exp_b [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        drive(0, 1'b1, 1'b1, BASE + 32'h24, DSIZE_W, 1'b1, 32'h3333_3333);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, BASE + 32'h28, DSIZE_W, 1'b1, 32'h4444_4444);
        for (int s = 0; s < 6; s++) begin
            total++;
            if (bus0.dbusy !== exp_b[s]) begin
                bad++;
                $display("FAIL b2b_dbusy sample %0d: got=%b want=%b", s, bus0.dbusy, exp_b[s]);
            end
            if (s == 3) drive(0, 1'b0, 1'b0, 32'd0, DSIZE_W, 1'b0, 32'd0);
            @(negedge clk);
        end
        $display("back-to-back stores u0 addr=%h,%h busy pattern sampled", BASE + 32'h24, BASE + 32'h28);
        do_load(0, BASE + 32'h24, DSIZE_W, 32'h3333_3333, 1);
        do_load(0, BASE + 32'h28, DSIZE_W, 32'h4444_4444, 1);
    endtask

    task automatic test_out_of_range();
        logic [31:0] oor, last, below;
        oor   = BASE + 32'(4 * DEPTH);
        last  = BASE + 32'(4 * (DEPTH - 1));
        below = BASE - 32'd4;
        do_store(0, BASE, DSIZE_W, 32'h0BAD_F00D, 1'b1, 2);
        do_store(0, last, DSIZE_W, 32'h600D_CAFE, 1'b1, 2);
        do_load(0, oor, DSIZE_W, 32'd0, 1);
        do_store(0, oor, DSIZE_W, 32'h5555_5555, 1'b1, 2);
        do_store(0, below, DSIZE_W, 32'h6666_6666, 1'b1, 2);
        do_load(0, BASE, DSIZE_W, 32'h0BAD_F00D, 1);
        do_load(0, last, DSIZE_W, 32'h600D_CAFE, 1);
        do_load(0, below, DSIZE_W, 32'd0, 1);
        do_load(0, oor + 32'd3, DSIZE_B, 32'd0, 1);
    endtask

    task automatic test_drop_in_rwait();
        int n;
        logic seen;
        logic [31:0] want;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, BASE + 32'h40, DSIZE_W, 1'b0, 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, BASE + 32'h40, DSIZE_W, 1'b0, 32'd0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 8) begin
            if (bus1.dready_n === 1'b0) seen = 1'b1;
            else begin @(negedge clk); n++; end
        end
        want = exp_q.pop_front();
        total++;
        if (!seen || ddata1 !== want) begin
            bad++;
            $display("FAIL drop_in_rwait: seen=%b got=%h want=%h", seen, ddata1, want);
        end
        @(negedge clk);
        $display("load u1 addr=%h dropped in RWAIT data=%h", BASE + 32'h40, want);
    endtask

    task automatic test_reset_midop();
        do_store(1, BASE + 32'h40, DSIZE_W, 32'hDEAD_BEEF, 1'b1, 2);
        do_load(1, BASE + 32'h40, DSIZE_W, 32'hDEAD_BEEF, 3);
        test_drop_in_rwait();
        @(negedge clk);
        drive(1, 1'b1, 1'b0, BASE + 32'h40, DSIZE_W, 1'b0, 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        drive(1, 1'b0, 1'b0, 32'd0, DSIZE_W, 1'b0, 32'd0);
        #1;
        total++;
        if (bus1.dready_n !== 1'b1 || bus1.dbusy !== 1'b0) begin
            bad++;
            $display("FAIL rwait_reset_outputs: dready_n=%b dbusy=%b want 1 0", bus1.dready_n, bus1.dbusy);
        end
        @(negedge clk);
        rst1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus1.dready_n !== 1'b1) begin
                bad++;
                $display("FAIL rwait_aborted cycle %0d: dready_n=%b want 1", i, bus1.dready_n);
            end
        end
        $display("reset during RWAIT u1: load aborted");
        do_store(1, BASE + 32'h40, DSIZE_W, 32'h2222_2222, 1'b0, -1);
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        total++;
        if (bus1.dbusy !== 1'b0) begin
            bad++;
            $display("FAIL busy_reset: dbusy=%b want 0", bus1.dbusy);
        end
        @(negedge clk);
        rst1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus1.dbusy !== 1'b0) begin
                bad++;
                $display("FAIL busy_after_reset: dbusy=%b want 0", bus1.dbusy);
            end
        end
        $display("reset during dbusy u1: buffered store discarded");
        do_load(1, BASE + 32'h40, DSIZE_W, 32'hDEAD_BEEF, 3);
    endtask

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, DSIZE_W, 1'b0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, DSIZE_W, 1'b0, 32'd0);
        test_reset();
        test_word_rw();
        test_subword();
        test_raw_order();
        test_back_to_back();
        test_out_of_range();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
